// File: rtl/reg_file_p.sv
// Parametrised multi-port register file with optional zero register,
// same-cycle write bypass and a sequenced whole-array clear.
module reg_file_p #(
  parameter int WIDTH   = 8,
  parameter int AW      = 4,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          write_register,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] data_out,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   write_dropped
);

  localparam int DEPTH = 2 ** AW;

  localparam logic IDLE  = 1'b0;
  localparam logic CLEAR = 1'b1;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic              state;
  logic [AW-1:0]     cnt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic zero_on;
  logic byp_on;
  logic wr_ok;

  assign zero_on = (ZERO_R0 != 0);
  assign byp_on  = (BYPASS != 0) && RegWrite
                && (state == IDLE);
  assign wr_ok   = RegWrite && (state == IDLE)
                && !(zero_on && (write_register == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      state         <= IDLE;
      cnt           <= '0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      clear_done    <= 1'b0;
      write_dropped <= 1'b0;
      case (state)
        IDLE: begin
          // a write on the request edge still lands
          if (wr_ok)
            mem[write_register] <= data_in;
          if (clear_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cnt]      <= '0;
          cnt           <= cnt + 1'b1;
          write_dropped <= RegWrite;
          if (cnt == LAST) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = raddr[g*AW +: AW];

    always_comb begin
      rd = mem[ra];
      if (zero_on && (ra == '0))
        rd = '0;
      else if (byp_on && (ra == write_register))
        rd = data_in;
    end

    assign data_out[g*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_reg_file_p.sv
// Directed bench for reg_file_p: three parameter sets, expected values
// queued at drive time and popped at each check point.
module tb_reg_file_p;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // default parameters
  logic        a_we;
  logic [3:0]  a_wa;
  logic [7:0]  a_wd;
  logic [7:0]  a_ra;
  logic [15:0] a_do;
  logic        a_clr, a_busy, a_done, a_drop;

  // BYPASS=1, ZERO_R0=1
  logic        b_we;
  logic [3:0]  b_wa;
  logic [7:0]  b_wd;
  logic [7:0]  b_ra;
  logic [15:0] b_do;
  logic        b_clr, b_busy, b_done, b_drop;

  // NREAD=3, WIDTH=16, AW=5
  logic        c_we;
  logic [4:0]  c_wa;
  logic [15:0] c_wd;
  logic [14:0] c_ra;
  logic [47:0] c_do;
  logic        c_clr, c_busy, c_done, c_drop;

  reg_file_p u_a (
    .clk(clk), .rst_n(rst_n), .RegWrite(a_we),
    .write_register(a_wa), .data_in(a_wd),
    .raddr(a_ra), .data_out(a_do),
    .clear_req(a_clr), .clear_busy(a_busy),
    .clear_done(a_done), .write_dropped(a_drop)
  );

  reg_file_p #(.BYPASS(1), .ZERO_R0(1)) u_b (
    .clk(clk), .rst_n(rst_n), .RegWrite(b_we),
    .write_register(b_wa), .data_in(b_wd),
    .raddr(b_ra), .data_out(b_do),
    .clear_req(b_clr), .clear_busy(b_busy),
    .clear_done(b_done), .write_dropped(b_drop)
  );

  reg_file_p #(.WIDTH(16), .AW(5), .NREAD(3)) u_c (
    .clk(clk), .rst_n(rst_n), .RegWrite(c_we),
    .write_register(c_wa), .data_in(c_wd),
    .raddr(c_ra), .data_out(c_do),
    .clear_req(c_clr), .clear_busy(c_busy),
    .clear_done(c_done), .write_dropped(c_drop)
  );

  logic [31:0] sb [$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] e);
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  int busy_n;
  int lim;

  initial begin
    rst_n = 1'b0;
    a_we = 0; a_wa = 0; a_wd = 0; a_ra = 0; a_clr = 0;
    b_we = 0; b_wa = 0; b_wd = 0; b_ra = 0; b_clr = 0;
    c_we = 0; c_wa = 0; c_wd = 0; c_ra = 0; c_clr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    a_ra = {4'd9, 4'd14};
    #1;
    push(32'h0); check("rst_a_do", {16'h0, a_do});
    push(32'h0); check("rst_c_do", c_do[31:0]);
    push(32'h0); check("rst_flags", {a_busy, a_done, a_drop});

    // default config writes
    a_we = 1; a_wa = 4'd14; a_wd = 8'd255;
    push(32'd255);
    tick();
    check("a_wr14", {24'h0, a_do[7:0]});
    a_wa = 4'd9; a_wd = 8'd200;
    push(32'd200); push(32'd255);
    tick();
    check("a_wr9", {24'h0, a_do[15:8]});
    check("a_keep14", {24'h0, a_do[7:0]});

    // RegWrite gating
    a_we = 0; a_wa = 4'd3; a_wd = 8'd155; a_ra = {4'd3, 4'd3};
    push(32'd0);
    tick();
    check("a_nowe", {24'h0, a_do[7:0]});
    a_we = 1; a_wa = 4'd3; a_wd = 8'd1;
    tick();
    a_wa = 4'd4; a_wd = 8'd2;
    tick();
    a_we = 0; a_ra = {4'd4, 4'd3};
    #1;
    push(32'd1); check("a_r3", {24'h0, a_do[7:0]});
    push(32'd2); check("a_r4", {24'h0, a_do[15:8]});

    // no bypass by default: old value until the edge
    a_we = 1; a_wa = 4'd4; a_wd = 8'd99;
    #1;
    push(32'd2); check("a_nobyp", {24'h0, a_do[15:8]});
    push(32'd99);
    tick();
    a_we = 0;
    check("a_r4_new", {24'h0, a_do[15:8]});

    // bypass + zero register
    b_we = 1; b_wa = 4'd5; b_wd = 8'h5A; b_ra = {4'd0, 4'd5};
    #1;
    push(32'h5A); check("b_byp", {24'h0, b_do[7:0]});
    push(32'h5A);
    tick();
    b_we = 0;
    #1;
    check("b_stored", {24'h0, b_do[7:0]});
    b_we = 1; b_wa = 4'd0; b_wd = 8'h77; b_ra = {4'd0, 4'd0};
    #1;
    push(32'h0); check("b_r0_pre", {24'h0, b_do[15:8]});
    push(32'h0);
    tick();
    b_we = 0;
    #1;
    check("b_r0_post", {24'h0, b_do[15:8]});

    // wide, three ports
    c_we = 1; c_wa = 5'd31; c_wd = 16'hBEEF;
    tick();
    c_wa = 5'd17; c_wd = 16'h1234;
    tick();
    c_we = 0; c_ra = {5'd31, 5'd17, 5'd31};
    #1;
    push(32'hBEEF); check("c_p0", {16'h0, c_do[15:0]});
    push(32'h1234); check("c_p1", {16'h0, c_do[31:16]});
    push(32'hBEEF); check("c_p2", {16'h0, c_do[47:32]});

    // fill A then clear it
    a_we = 1;
    for (int i = 0; i < 16; i++) begin
      a_wa = 4'(i); a_wd = 8'(i + 1);
      tick();
    end
    a_we = 0; a_ra = {4'd15, 4'd7};
    #1;
    push(32'd16); check("a_fill15", {24'h0, a_do[15:8]});
    a_clr = 1;
    tick();
    a_clr = 0;
    busy_n = 0; lim = 0;
    while (a_busy && lim < 40) begin
      busy_n++;
      if (busy_n == 3) begin
        a_we = 1; a_wa = 4'd15; a_wd = 8'hAA;
        push(32'd1);
      end
      tick();
      if (busy_n == 3) begin
        a_we = 0;
        check("a_drop", {31'h0, a_drop});
      end
      lim++;
    end
    push(32'd16); check("a_busy_len", busy_n);
    push(32'd1);  check("a_done", {31'h0, a_done});
    tick();
    push(32'd0);  check("a_done_1cyc", {31'h0, a_done});
    for (int i = 0; i < 16; i += 2) begin
      a_ra = {4'(i + 1), 4'(i)};
      #1;
      push(32'h0);
      check("a_cleared", {16'h0, a_do});
    end

    // reset in the middle of a clear
    a_we = 1; a_wa = 4'd12; a_wd = 8'h44;
    tick();
    a_we = 0; a_ra = {4'd0, 4'd12};
    a_clr = 1;
    tick();
    a_clr = 0;
    tick(); tick(); tick(); tick();
    push(32'h44); check("a_mid_r12", {24'h0, a_do[7:0]});
    push(32'h0);  check("a_mid_r0", {24'h0, a_do[15:8]});
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    push(32'h0); check("a_rst_flags", {a_busy, a_done});
    push(32'h0); check("a_rst_r12", {24'h0, a_do[7:0]});
    push(32'h0); check("c_rst", c_do[31:0]);
    tick(); tick(); tick();
    a_clr = 1;
    tick();
    a_clr = 0;
    busy_n = 0; lim = 0;
    while (a_busy && lim < 40) begin
      busy_n++;
      tick();
      lim++;
    end
    push(32'd16); check("a_busy_len2", busy_n);
    push(32'd1);  check("a_done2", {31'h0, a_done});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_p.md
# reg_file_p

Parametrised successor to the 16×8 two-read/one-write register file used by the datapath. It provides:
- configurable data width, register count and number of read ports;
- optional hard-wired zero register;
- optional same-cycle write-to-read bypass;
- a multi-cycle clear sequencer that zeroes the whole array without a reset.

It sits between decode (read addresses) and writeback (write port) in the core pipeline.

## Interface
Parameters:
- WIDTH, 8, data width in bits.
- AW, 4, address width; DEPTH = 2**AW registers.
- NREAD, 2, number of independent read ports (1..4).
- ZERO_R0, 0, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 0, when 1 a read of the register being written this cycle returns data_in.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- RegWrite  input  1  write enable.
- write_register  input  AW  write address.
- data_in  input  WIDTH  write data.
- raddr  input  NREAD*AW  read addresses; port i is raddr[i*AW +: AW].
- data_out  output  NREAD*WIDTH  read data; port i is data_out[i*WIDTH +: WIDTH].
- clear_req  input  1  request to zero the entire array.
- clear_busy  output  1  high while the clear sequence is running.
- clear_done  output  1  one-cycle pulse when the clear sequence completes.
- write_dropped  output  1  registered; high for one cycle after a RegWrite that was ignored because a clear was running.

## Operation
- Storage is DEPTH×WIDTH flops.
- Writes: mem[write_register] <= data_in on a rising edge when RegWrite=1, state=IDLE and the write is not blocked by ZERO_R0 (write_register=0 with ZERO_R0=1).
- Reads are combinational and independent per port. Port i returns:
  - 0, if ZERO_R0=1 and raddr_i=0;
  - otherwise data_in, if BYPASS=1, RegWrite=1, state=IDLE and raddr_i=write_register;
  - otherwise mem[raddr_i].
- Several ports may read the same address; each returns identical data.
- Clear FSM states:
  - IDLE:
    - clear_req=1 at an edge -> CLEAR with cnt<=0 and clear_busy<=1.
    - A RegWrite at that same edge still commits, because the state was IDLE.
  - CLEAR:
    - Each edge performs mem[cnt]<=0 and cnt<=cnt+1.
    - At the edge where cnt=DEPTH-1 the FSM returns to IDLE, sets clear_busy<=0 and clear_done<=1.
- During CLEAR:
  - RegWrite is ignored. write_dropped<=1 on each edge where RegWrite=1; otherwise write_dropped<=0.
  - clear_req is ignored; requests are not queued.
  - Bypass is disabled.
  - Reads return current storage, so registers below cnt are already 0.
- cnt is AW bits wide and is not observable. It wraps only at the terminal count, which ends the sequence.

## Timing
- Reset (rst_n=0 at an edge) has priority over everything. On reset:
  - all mem entries <= 0;
  - state <= IDLE, cnt <= 0;
  - clear_busy, clear_done and write_dropped <= 0.
- data_out is 0 on all ports after reset until the first write.
- Write latency: data written at edge k is visible on data_out from just after edge k. With BYPASS=1 it is also visible combinationally in the cycle before edge k.
- Clear latency, for clear_req sampled at edge k:
  - clear_busy is high from after edge k through edge k+DEPTH;
  - clear_done is high for exactly the cycle after edge k+DEPTH;
  - a write can commit again at edge k+DEPTH+1.
- A clear_req held high continuously retriggers a new sequence: in IDLE at edge k+DEPTH+1, a new CLEAR starts.
- Reset mid-clear aborts the sequence immediately. clear_done does not pulse.

## Test plan
- Reset/default params: hold rst_n=0 for 2 edges, then write 255 to reg 14 and 200 to reg 9, with raddr0=14, raddr1=9 -> data_out0=255, data_out1=200 from the edge after each write.
- RegWrite gating: RegWrite=0, write_register=3, data_in=155 -> reg 3 reads 0. Then write 1 to reg 3 and 2 to reg 4, and read both ports -> 1 and 2.
- BYPASS=1, ZERO_R0=1:
  - Drive RegWrite=1, write_register=5, data_in=0x5A with raddr0=5 -> data_out0=0x5A before the edge.
  - Write 0x77 to reg 0 with raddr1=0 -> data_out1=0 before and after the edge.
- Clear sequence: fill regs 0..15 with value=addr+1, pulse clear_req for 1 cycle -> clear_busy high exactly 16 cycles, then clear_done high 1 cycle, then all 16 regs read 0.
  - A RegWrite of 0xAA to reg 15 during busy -> write_dropped pulses and reg 15 reads 0 afterwards.
- Reset mid-clear: assert rst_n=0 at the 5th clear cycle -> clear_busy=0 and clear_done=0 next cycle, all registers 0.
  - A clear_req 3 cycles later runs the full 16 cycles.
- NREAD=3, WIDTH=16, AW=5: write 0xBEEF to reg 31 and 0x1234 to reg 17 -> ports read 0xBEEF, 0x1234, 0xBEEF for raddr = 31, 17, 31.
